// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared UART definitions (state enum, data width, baud divider)|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    // Shared with the transmitter so both ends derive the same bit period.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_if : received-byte valid/ready port plus error pulses            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] dout;
    logic                 dout_vld;
    logic                 dout_rdy;
    logic                 frame_err;
    logic                 overrun;

    modport master (output dout, dout_vld, frame_err, overrun, input dout_rdy);
    modport slave  (input dout, dout_vld, frame_err, overrun, output dout_rdy);

endinterface
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync2 : two-flop synchronizer for asynchronous pad inputs                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sync2 #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx : 8N1 receiver with one-entry valid/ready output buffer          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      rxd,
    uart_rx_if.master bus
);

    localparam int c_DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int c_HALF  = c_DIV / 2;
    localparam int c_CNT_W = $clog2(c_DIV);
    localparam int c_IDX_W = $clog2(DATA_BITS);

    localparam logic [c_CNT_W-1:0] c_DIV_LAST  = c_CNT_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);

    logic                 w_rxs;
    logic                 w_consume;

    rx_state_e            state_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic [c_IDX_W-1:0]   idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 done_q;
    logic                 ferr_q;

    logic [DATA_BITS-1:0] dout_q;
    logic                 dout_vld_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync_rxd (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (rxd),
        .q_o  (w_rxs)
    );

    // The counter free-runs and wraps; every state entry forces it back to 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            cnt_q  <= (cnt_q == c_DIV_LAST) ? '0 : cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (!w_rxs) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == c_HALF_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= w_rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == c_DIV_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= w_rxs;
                        if (idx_q == c_IDX_LAST) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (cnt_q == c_DIV_LAST) begin
                        cnt_q <= '0;
                        if (w_rxs) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (w_rxs) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign w_consume = dout_vld_q & bus.dout_rdy;

    // A consume in the completion cycle frees the slot for the new byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= ferr_q;
            overrun_q   <= done_q & dout_vld_q & ~bus.dout_rdy;
            if (done_q && (!dout_vld_q || w_consume)) begin
                dout_q     <= shift_q;
                dout_vld_q <= 1'b1;
            end else if (w_consume) begin
                dout_vld_q <= 1'b0;
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx : randomized bench for uart_rx with a frame-level model       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_rx;

    localparam int c_DIV  = 16;
    localparam int c_HALF = 8;
    localparam int c_LAT  = 2 + 1 + c_HALF + 9 * c_DIV + 1;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         ferr;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic rxd  = 1'b1;
    logic rdy  = 1'b0;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;

    exp_t       q_exp[$];
    logic [7:0] m_dout = 8'h00;
    bit         m_vld  = 1'b0;
    bit         m_ferr = 1'b0;
    bit         m_ovr  = 1'b0;

    int   vld_rises = 0;
    int   ferr_seen = 0;
    int   ovr_seen  = 0;
    int   last_rise = 0;
    bit   prev_vld  = 1'b0;

    int   rdy_mode  = 0;
    bit   rdy_fix   = 1'b0;
    int   pulse_cyc = -1;

    uart_rx_if u_if ();

    assign u_if.dout_rdy = rdy;

    uart_rx #(
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .rxd  (rxd),
        .bus  (u_if.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame-level model: each accepted frame yields one event at start + latency.
    always @(posedge clk) begin
        exp_t       e;
        bit         consume;
        bit         done;
        bit         bad;
        logic [7:0] data;
        cyc = cyc + 1;
        if (!rstn) begin
            m_dout = 8'h00;
            m_vld  = 1'b0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            q_exp.delete();
        end else begin
            consume = m_vld && rdy;
            done    = 1'b0;
            bad     = 1'b0;
            data    = 8'h00;
            if (q_exp.size() > 0 && q_exp[0].due <= cyc) begin
                e    = q_exp.pop_front();
                done = !e.ferr;
                bad  = e.ferr;
                data = e.data;
            end
            m_ferr = bad;
            m_ovr  = 1'b0;
            if (consume) m_vld = 1'b0;
            if (done) begin
                if (m_vld) begin
                    m_ovr = 1'b1;
                end else begin
                    m_dout = data;
                    m_vld  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            check_eq("dout",      32'(u_if.dout),      32'(m_dout));
            check_eq("dout_vld",  32'(u_if.dout_vld),  32'(m_vld));
            check_eq("frame_err", 32'(u_if.frame_err), 32'(m_ferr));
            check_eq("overrun",   32'(u_if.overrun),   32'(m_ovr));
            if (u_if.dout_vld && !prev_vld) begin
                vld_rises++;
                last_rise = cyc;
            end
            if (u_if.frame_err) ferr_seen++;
            if (u_if.overrun)   ovr_seen++;
        end
        prev_vld = u_if.dout_vld;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rdy = rdy_fix;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc == pulse_cyc);
            endcase
        end
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int extra_low,
                             output int start);
        exp_t       e;
        logic [9:0] frame;
        start  = cyc;
        e.due  = start + c_LAT;
        e.data = b;
        e.ferr = !stop_ok;
        q_exp.push_back(e);
        frame = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            idle(c_DIV);
        end
        if (!stop_ok) idle(extra_low);
        rxd = 1'b1;
    endtask

    initial begin
        int r0, f0, o0, s;

        rstn = 1'b0;
        idle(5);
        check_eq("rst_dout",      32'(u_if.dout),      32'h00);
        check_eq("rst_dout_vld",  32'(u_if.dout_vld),  32'h0);
        check_eq("rst_frame_err", 32'(u_if.frame_err), 32'h0);
        check_eq("rst_overrun",   32'(u_if.overrun),   32'h0);
        rstn = 1'b1;
        idle(10);

        // single byte with the consumer always ready
        rdy_mode = 0;
        rdy_fix  = 1'b1;
        r0 = vld_rises; f0 = ferr_seen; o0 = ovr_seen;
        send_byte(8'hA5, 1'b1, 0, s);
        idle(5);
        check_eq("single_latency", 32'(last_rise - s), 32'(c_LAT));
        check_eq("single_rises",   32'(vld_rises - r0), 32'd1);
        check_eq("single_data",    32'(u_if.dout), 32'hA5);
        check_eq("single_vld_low", 32'(u_if.dout_vld), 32'h0);
        check_eq("single_errs",    32'((ferr_seen - f0) + (ovr_seen - o0)), 32'd0);

        // short low glitch must be rejected
        r0 = vld_rises; f0 = ferr_seen;
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(30);
        check_eq("glitch_rises", 32'(vld_rises - r0), 32'd0);
        check_eq("glitch_ferr",  32'(ferr_seen - f0), 32'd0);
        send_byte(8'h3C, 1'b1, 0, s);
        idle(5);
        check_eq("glitch_next_data",  32'(u_if.dout), 32'h3C);
        check_eq("glitch_next_rises", 32'(vld_rises - r0), 32'd1);

        // framing error followed by a held-low line
        r0 = vld_rises; f0 = ferr_seen;
        send_byte(8'h55, 1'b0, 40, s);
        idle(20);
        check_eq("ferr_pulses", 32'(ferr_seen - f0), 32'd1);
        check_eq("ferr_rises",  32'(vld_rises - r0), 32'd0);
        send_byte(8'h0F, 1'b1, 0, s);
        idle(5);
        check_eq("ferr_next_data", 32'(u_if.dout), 32'h0F);

        // overrun: two bytes arrive while the consumer stalls
        rdy_fix = 1'b0;
        idle(2);
        o0 = ovr_seen;
        send_byte(8'h11, 1'b1, 0, s);
        send_byte(8'h22, 1'b1, 0, s);
        idle(5);
        check_eq("ovr_pulses", 32'(ovr_seen - o0), 32'd1);
        check_eq("ovr_kept",   32'(u_if.dout), 32'h11);
        check_eq("ovr_vld",    32'(u_if.dout_vld), 32'h1);
        rdy_fix = 1'b1;
        idle(3);
        check_eq("ovr_drained_vld",  32'(u_if.dout_vld), 32'h0);
        check_eq("ovr_drained_dout", 32'(u_if.dout), 32'h11);

        // consume exactly in the completion cycle of the second byte
        rdy_fix   = 1'b0;
        idle(2);
        o0 = ovr_seen; r0 = vld_rises;
        pulse_cyc = cyc + 10 * c_DIV + c_LAT - 1;
        rdy_mode  = 2;
        send_byte(8'h11, 1'b1, 0, s);
        send_byte(8'h22, 1'b1, 0, s);
        idle(5);
        check_eq("simul_ovr",   32'(ovr_seen - o0), 32'd0);
        check_eq("simul_data",  32'(u_if.dout), 32'h22);
        check_eq("simul_vld",   32'(u_if.dout_vld), 32'h1);
        check_eq("simul_rises", 32'(vld_rises - r0), 32'd1);
        rdy_mode = 0;
        rdy_fix  = 1'b1;
        idle(3);

        // random bytes, gaps and consumer back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 12; i++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b1, 0, s);
            idle($urandom_range(0, 20));
        end
        rdy_mode = 0;
        rdy_fix  = 1'b1;
        idle(20);

        // reset during data bit 4 of 0xFF with a byte still pending
        rdy_fix = 1'b0;
        idle(2);
        send_byte(8'h5A, 1'b1, 0, s);
        idle(5);
        rxd = 1'b0;
        idle(c_DIV);
        rxd = 1'b1;
        idle(4 * c_DIV + c_HALF);
        rstn = 1'b0;
        #1;
        check_eq("midrst_dout",      32'(u_if.dout),      32'h00);
        check_eq("midrst_dout_vld",  32'(u_if.dout_vld),  32'h0);
        check_eq("midrst_frame_err", 32'(u_if.frame_err), 32'h0);
        check_eq("midrst_overrun",   32'(u_if.overrun),   32'h0);
        idle(3);
        rstn    = 1'b1;
        rdy_fix = 1'b1;
        idle(10);
        r0 = vld_rises;
        send_byte(8'h81, 1'b1, 0, s);
        idle(5);
        check_eq("midrst_next_data",  32'(u_if.dout), 32'h81);
        check_eq("midrst_next_rises", 32'(vld_rises - r0), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
